// File: rtl/layer_hdr_pkg.sv
// Shared definitions for the layer header engine.
// Contents: register index constants, flag bit positions, the update FSM state
// enum, a header struct with sprite and text views, and small helper functions
// for register access, the per-frame sprite step and floor(log2).
package layer_hdr_pkg;

    localparam int HDR_DATA_W = 16;
    localparam int NUM_REGS   = 8;

    localparam logic [2:0] REG_FLAGS  = 3'd0;
    localparam logic [2:0] REG_WIDTH  = 3'd1;
    localparam logic [2:0] REG_HEIGHT = 3'd2;
    localparam logic [2:0] REG_POS_X  = 3'd3;
    localparam logic [2:0] REG_POS_Y  = 3'd4;
    localparam logic [2:0] REG_VEL_X  = 3'd5;
    localparam logic [2:0] REG_VEL_Y  = 3'd6;
    localparam logic [2:0] REG_ANIM   = 3'd7;
    localparam logic [2:0] REG_FONT   = 3'd5;
    localparam logic [2:0] REG_CHARS  = 3'd6;

    localparam int FLAG_POPULATED = 0;
    localparam int FLAG_SPRITE    = 1;
    localparam int FLAG_HIDDEN    = 2;
    localparam int FLAG_ANIMATED  = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} upd_state_t;

    // First field is the MSB, so register N sits at bits [16*N +: 16].
    typedef struct packed {
        logic [15:0] anim;      // [15:8] current frame, [7:0] frame count
        logic [15:0] vel_y;
        logic [15:0] vel_x;
        logic [15:0] pos_y;
        logic [15:0] pos_x;
        logic [15:0] height;
        logic [15:0] width;
        logic [15:0] flags;
    } sprite_hdr_t;

    typedef struct packed {
        logic [15:0] rsvd;
        logic [15:0] char_count;
        logic [15:0] font_index;
        logic [15:0] pos_y;
        logic [15:0] pos_x;
        logic [15:0] height;
        logic [15:0] width;
        logic [15:0] flags;
    } text_hdr_t;

    typedef union packed {
        sprite_hdr_t spr;
        text_hdr_t   txt;
    } hdr_t;

    function automatic logic [HDR_DATA_W-1:0] hdr_get(hdr_t h, logic [2:0] idx);
        logic [NUM_REGS*HDR_DATA_W-1:0] flat;
        flat = h;
        return flat[{idx, 4'b0000} +: HDR_DATA_W];
    endfunction

    function automatic hdr_t hdr_set(hdr_t h, logic [2:0] idx, logic [HDR_DATA_W-1:0] v);
        logic [NUM_REGS*HDR_DATA_W-1:0] flat;
        flat = h;
        flat[{idx, 4'b0000} +: HDR_DATA_W] = v;
        return hdr_t'(flat);
    endfunction

    // Position += velocity; animated sprites advance one frame, wrapping at
    // the frame count (a count of 0 or 1 pins the frame at 0).
    function automatic hdr_t sprite_step(hdr_t h);
        hdr_t       n;
        logic [8:0] nxt;
        n = h;
        if (h.spr.flags[FLAG_POPULATED] && h.spr.flags[FLAG_SPRITE]) begin
            n.spr.pos_x = h.spr.pos_x + h.spr.vel_x;
            n.spr.pos_y = h.spr.pos_y + h.spr.vel_y;
            if (h.spr.flags[FLAG_ANIMATED]) begin
                nxt = {1'b0, h.spr.anim[15:8]} + 9'd1;
                n.spr.anim[15:8] = (nxt >= {1'b0, h.spr.anim[7:0]}) ? 8'd0 : nxt[7:0];
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] floor_log2(logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/layer_pixel_lookup.sv
// Two-stage pixel lookup for the render pipeline.
// Stage 1 captures the selected header fields and the layer-relative
// coordinates; stage 2 registers the bounds-checked memory enables and data.
// Ports: clk, reset (async, active-low), pix_valid/pix_hdr/pix_x/pix_y in;
// out_valid, read_ram_en, read_flash_en, layer_id, layer_width, layer_height,
// layer_x, layer_y, sprite_frame, font_index, char_index out.
module layer_pixel_lookup
    import layer_hdr_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int COORD_W = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_valid,
    input  hdr_t                     pix_hdr,
    input  logic [COORD_W-1:0]       pix_x,
    input  logic [COORD_W-1:0]       pix_y,
    output logic                     out_valid,
    output logic                     read_ram_en,
    output logic                     read_flash_en,
    output logic [7:0]               layer_id,
    output logic [DATA_W-1:0]        layer_width,
    output logic [DATA_W-1:0]        layer_height,
    output logic signed [DATA_W-1:0] layer_x,
    output logic signed [DATA_W-1:0] layer_y,
    output logic [7:0]               sprite_frame,
    output logic [DATA_W-1:0]        font_index,
    output logic [DATA_W-1:0]        char_index
);

    logic              s1_valid, s1_vis, s1_sprite;
    logic [7:0]        s1_id, s1_frame;
    logic [DATA_W-1:0] s1_width, s1_height, s1_font, s1_chars, s1_lx, s1_ly;

    logic              in_y, in_x_spr, in_x_txt;
    logic [31:0]       txt_limit;
    logic [DATA_W-1:0] char_idx;

    // Frame count and the upper flag bits play no part in the lookup.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{pix_hdr.spr.flags[7:3], pix_hdr.spr.anim[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_vis    <= 1'b0;
            s1_sprite <= 1'b0;
            s1_id     <= '0;
            s1_frame  <= '0;
            s1_width  <= '0;
            s1_height <= '0;
            s1_font   <= '0;
            s1_chars  <= '0;
            s1_lx     <= '0;
            s1_ly     <= '0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                s1_vis    <= pix_hdr.spr.flags[FLAG_POPULATED] & ~pix_hdr.spr.flags[FLAG_HIDDEN];
                s1_sprite <= pix_hdr.spr.flags[FLAG_SPRITE];
                s1_id     <= pix_hdr.spr.flags[15:8];
                s1_frame  <= pix_hdr.spr.anim[15:8];
                s1_width  <= pix_hdr.spr.width;
                s1_height <= pix_hdr.spr.height;
                s1_font   <= pix_hdr.txt.font_index;
                s1_chars  <= pix_hdr.txt.char_count;
                s1_lx     <= DATA_W'(pix_x) - pix_hdr.spr.pos_x;
                s1_ly     <= DATA_W'(pix_y) - pix_hdr.spr.pos_y;
            end
        end
    end

    // Negative relative coordinates (MSB set) are always out of bounds.
    always_comb begin
        in_y      = ~s1_ly[DATA_W-1] & (s1_ly < s1_height);
        in_x_spr  = ~s1_lx[DATA_W-1] & (s1_lx < s1_width);
        txt_limit = 32'(s1_width) * 32'(s1_chars);
        in_x_txt  = ~s1_lx[DATA_W-1] & (32'(s1_lx) < txt_limit);
        char_idx  = (s1_width == '0) ? '0 : (s1_lx >> floor_log2(s1_width));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            read_ram_en   <= 1'b0;
            read_flash_en <= 1'b0;
            layer_id      <= '0;
            layer_width   <= '0;
            layer_height  <= '0;
            layer_x       <= '0;
            layer_y       <= '0;
            sprite_frame  <= '0;
            font_index    <= '0;
            char_index    <= '0;
        end else begin
            out_valid     <= s1_valid;
            read_ram_en   <= s1_valid & s1_vis & in_y & (s1_sprite ? in_x_spr : in_x_txt);
            read_flash_en <= s1_valid & s1_vis & in_y & ~s1_sprite & in_x_txt;
            if (s1_valid) begin
                layer_id     <= s1_id;
                layer_width  <= s1_width;
                layer_height <= s1_height;
                layer_x      <= $signed(s1_lx);
                layer_y      <= $signed(s1_ly);
                sprite_frame <= s1_frame;
                font_index   <= s1_font;
                char_index   <= char_idx;
            end
        end
    end

endmodule

// File: rtl/layer_header_engine.sv
// Layer header store with controller port, clear, pixel lookup and a
// frame-start sprite update sweep.
// Ports: clk, reset (async, active-low); ctrl_* ready/valid register access
// with ctrl_rdata/ctrl_rvalid read return; clear_valid/clear_layer; frame_start
// with update_busy/update_done/update_overrun status; pix_* lookup request and
// the registered lookup results from layer_pixel_lookup.
//
// Update FSM states:
//   ST_IDLE | waiting for frame_start
//   ST_RD   | latch header of layer upd_idx_q
//   ST_WR   | write back stepped header, advance or finish
//   ST_DONE | one cycle after the sweep, update_done high
module layer_header_engine
    import layer_hdr_pkg::*;
#(
    parameter int NUM_LAYERS = 32,
    parameter int LAYER_W    = 5,
    parameter int DATA_W     = 16,
    parameter int COORD_W    = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ctrl_valid,
    output logic                     ctrl_ready,
    input  logic                     ctrl_write,
    input  logic [LAYER_W-1:0]       ctrl_layer,
    input  logic [2:0]               ctrl_reg,
    input  logic [DATA_W-1:0]        ctrl_wdata,
    output logic [DATA_W-1:0]        ctrl_rdata,
    output logic                     ctrl_rvalid,
    input  logic                     clear_valid,
    input  logic [LAYER_W-1:0]       clear_layer,
    input  logic                     frame_start,
    output logic                     update_busy,
    output logic                     update_done,
    output logic                     update_overrun,
    input  logic                     pix_valid,
    input  logic [LAYER_W-1:0]       pix_layer,
    input  logic [COORD_W-1:0]       pix_x,
    input  logic [COORD_W-1:0]       pix_y,
    output logic                     out_valid,
    output logic                     read_ram_en,
    output logic                     read_flash_en,
    output logic [7:0]               layer_id,
    output logic [DATA_W-1:0]        layer_width,
    output logic [DATA_W-1:0]        layer_height,
    output logic signed [DATA_W-1:0] layer_x,
    output logic signed [DATA_W-1:0] layer_y,
    output logic [7:0]               sprite_frame,
    output logic [DATA_W-1:0]        font_index,
    output logic [DATA_W-1:0]        char_index
);

    hdr_t               hdr_q [NUM_LAYERS];
    hdr_t               upd_hdr_q;
    hdr_t               pix_hdr;
    upd_state_t         state_q;
    logic [LAYER_W-1:0] upd_idx_q;
    logic               ready_q;
    logic               ctrl_acc;

    // ready_q holds the port off until the first edge after reset release.
    assign ctrl_ready = ready_q & ~update_busy;
    assign ctrl_acc   = ctrl_valid & ctrl_ready;
    assign pix_hdr    = hdr_q[pix_layer];

    // The controller is stalled during the sweep, so ctrl writes and sweep
    // writes never collide; a clear is placed last so it beats a same-edge write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) hdr_q[i] <= '0;
        end else begin
            if (ctrl_acc && ctrl_write)
                hdr_q[ctrl_layer] <= hdr_set(hdr_q[ctrl_layer], ctrl_reg, ctrl_wdata);
            if (state_q == ST_WR)
                hdr_q[upd_idx_q] <= sprite_step(upd_hdr_q);
            if (clear_valid && !update_busy)
                hdr_q[clear_layer] <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q     <= 1'b0;
            ctrl_rvalid <= 1'b0;
            ctrl_rdata  <= '0;
        end else begin
            ready_q     <= 1'b1;
            ctrl_rvalid <= ctrl_acc & ~ctrl_write;
            if (ctrl_acc && !ctrl_write)
                ctrl_rdata <= hdr_get(hdr_q[ctrl_layer], ctrl_reg);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            upd_idx_q      <= '0;
            upd_hdr_q      <= '0;
            update_busy    <= 1'b0;
            update_done    <= 1'b0;
            update_overrun <= 1'b0;
        end else begin
            update_done    <= 1'b0;
            update_overrun <= frame_start & update_busy;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (frame_start) begin
                        state_q     <= ST_RD;
                        upd_idx_q   <= '0;
                        update_busy <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    upd_hdr_q <= hdr_q[upd_idx_q];
                    state_q   <= ST_WR;
                end
                ST_WR: begin
                    if (upd_idx_q == LAYER_W'(NUM_LAYERS - 1)) begin
                        state_q     <= ST_DONE;
                        update_busy <= 1'b0;
                        update_done <= 1'b1;
                    end else begin
                        upd_idx_q <= upd_idx_q + 1'b1;
                        state_q   <= ST_RD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    layer_pixel_lookup #(
        .DATA_W  (DATA_W),
        .COORD_W (COORD_W)
    ) u_lookup (
        .clk           (clk),
        .reset         (reset),
        .pix_valid     (pix_valid),
        .pix_hdr       (pix_hdr),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .out_valid     (out_valid),
        .read_ram_en   (read_ram_en),
        .read_flash_en (read_flash_en),
        .layer_id      (layer_id),
        .layer_width   (layer_width),
        .layer_height  (layer_height),
        .layer_x       (layer_x),
        .layer_y       (layer_y),
        .sprite_frame  (sprite_frame),
        .font_index    (font_index),
        .char_index    (char_index)
    );

endmodule

// File: tb/tb_layer_header_engine.sv
// Self-checking bench for layer_header_engine: a header model plus queues of
// expected read returns and pixel lookup results.
module tb_layer_header_engine;

    localparam int NL = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_valid = 1'b0, ctrl_write = 1'b0;
    logic [4:0]  ctrl_layer = '0;
    logic [2:0]  ctrl_reg = '0;
    logic [15:0] ctrl_wdata = '0;
    logic        clear_valid = 1'b0;
    logic [4:0]  clear_layer = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [4:0]  pix_layer = '0;
    logic [10:0] pix_x = '0, pix_y = '0;

    logic        ctrl_ready, ctrl_rvalid, update_busy, update_done, update_overrun;
    logic [15:0] ctrl_rdata;
    logic        out_valid, read_ram_en, read_flash_en;
    logic [7:0]  layer_id, sprite_frame;
    logic [15:0] layer_width, layer_height, font_index, char_index;
    logic signed [15:0] layer_x, layer_y;

    layer_header_engine dut (
        .clk(clk), .reset(reset),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_write(ctrl_write),
        .ctrl_layer(ctrl_layer), .ctrl_reg(ctrl_reg), .ctrl_wdata(ctrl_wdata),
        .ctrl_rdata(ctrl_rdata), .ctrl_rvalid(ctrl_rvalid),
        .clear_valid(clear_valid), .clear_layer(clear_layer),
        .frame_start(frame_start), .update_busy(update_busy),
        .update_done(update_done), .update_overrun(update_overrun),
        .pix_valid(pix_valid), .pix_layer(pix_layer), .pix_x(pix_x), .pix_y(pix_y),
        .out_valid(out_valid), .read_ram_en(read_ram_en), .read_flash_en(read_flash_en),
        .layer_id(layer_id), .layer_width(layer_width), .layer_height(layer_height),
        .layer_x(layer_x), .layer_y(layer_y), .sprite_frame(sprite_frame),
        .font_index(font_index), .char_index(char_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [15:0] mdl [NL][8];

    typedef struct {
        int          cyc;
        logic        ram, flash;
        logic [7:0]  id, frame;
        logic [15:0] w, h, lx, ly, font, ci;
    } pix_exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } rd_exp_t;

    pix_exp_t pixq[$];
    rd_exp_t  rdq[$];
    pix_exp_t pm;
    rd_exp_t  rm;
    int       done_cnt = 0;
    int       done_cyc = 0;

    function automatic pix_exp_t exp_pix(int l, int x, int y);
        pix_exp_t    e;
        logic [15:0] f, w, ht, lx, ly;
        logic [31:0] lim;
        logic        vis, spr, iny, inxs, inxt;
        int          k;
        f   = mdl[l][0];
        w   = mdl[l][1];
        ht  = mdl[l][2];
        lx  = 16'(x) - mdl[l][3];
        ly  = 16'(y) - mdl[l][4];
        vis = f[0] && !f[2];
        spr = f[1];
        iny  = !ly[15] && (ly < ht);
        inxs = !lx[15] && (lx < w);
        lim  = 32'(w) * 32'(mdl[l][6]);
        inxt = !lx[15] && (32'(lx) < lim);
        e.cyc   = 0;
        e.ram   = vis && iny && (spr ? inxs : inxt);
        e.flash = vis && iny && !spr && inxt;
        e.id    = f[15:8];
        e.frame = mdl[l][7][15:8];
        e.w     = w;
        e.h     = ht;
        e.lx    = lx;
        e.ly    = ly;
        e.font  = mdl[l][5];
        k = -1;
        for (int i = 0; i < 16; i++) if (w[i]) k = i;
        e.ci = (k < 0) ? 16'd0 : (lx >> k);
        return e;
    endfunction

    task automatic model_sweep();
        int nf;
        for (int l = 0; l < NL; l++) begin
            if (mdl[l][0][0] && mdl[l][0][1]) begin
                mdl[l][3] = mdl[l][3] + mdl[l][5];
                mdl[l][4] = mdl[l][4] + mdl[l][6];
                if (mdl[l][0][3]) begin
                    nf = int'(mdl[l][7][15:8]) + 1;
                    mdl[l][7][15:8] = (nf >= int'(mdl[l][7][7:0])) ? 8'd0 : 8'(nf);
                end
            end
        end
    endtask

    task automatic model_clear_all();
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < 8; r++) mdl[l][r] = '0;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ctrl_xfer(input bit wr, input int l, input int r, input logic [15:0] d);
        int guard;
        guard = 0;
        ctrl_valid = 1'b1;
        ctrl_write = wr;
        ctrl_layer = 5'(l);
        ctrl_reg   = 3'(r);
        ctrl_wdata = d;
        while (!ctrl_ready && guard < 1000) begin
            step();
            guard++;
        end
        if (!ctrl_ready) begin
            chk("ctrl_ready_timeout", 32'd0, 32'd1);
            ctrl_valid = 1'b0;
        end else begin
            if (!wr) begin
                rd_exp_t e;
                e.cyc = cyc + 1;
                e.d   = mdl[l][r];
                rdq.push_back(e);
            end
            step();
            ctrl_valid = 1'b0;
            if (wr) mdl[l][r] = d;
        end
    endtask

    task automatic do_pix(input int l, input int x, input int y);
        pix_exp_t e;
        e = exp_pix(l, x, y);
        e.cyc = cyc + 2;
        pixq.push_back(e);
        pix_valid = 1'b1;
        pix_layer = 5'(l);
        pix_x     = 11'(x);
        pix_y     = 11'(y);
        step();
        pix_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (update_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ctrl_rvalid) begin
                if (rdq.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    rm = rdq.pop_front();
                    chk("rd_latency", cyc, rm.cyc);
                    chk("rd_data", ctrl_rdata, rm.d);
                end
            end
            if (out_valid) begin
                if (pixq.size() == 0) chk("out_valid_unexpected", 32'd1, 32'd0);
                else begin
                    pm = pixq.pop_front();
                    chk("pix_latency", cyc, pm.cyc);
                    chk("read_ram_en", read_ram_en, pm.ram);
                    chk("read_flash_en", read_flash_en, pm.flash);
                    chk("layer_id", layer_id, pm.id);
                    chk("layer_width", layer_width, pm.w);
                    chk("layer_height", layer_height, pm.h);
                    chk("layer_x", $unsigned(layer_x), pm.lx);
                    chk("layer_y", $unsigned(layer_y), pm.ly);
                    chk("sprite_frame", sprite_frame, pm.frame);
                    chk("font_index", font_index, pm.font);
                    chk("char_index", char_index, pm.ci);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s;

    initial begin
        model_clear_all();
        step(3);
        chk("rst_ctrl_ready", ctrl_ready, 0);
        chk("rst_update_busy", update_busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ctrl_rvalid", ctrl_rvalid, 0);
        chk("rst_ctrl_rdata", ctrl_rdata, 0);
        reset = 1'b1;
        step();
        chk("ready_after_release", ctrl_ready, 1);

        // Sprite L3, text L0, hidden sprite L4, zero-width text L5
        ctrl_xfer(1, 3, 0, 16'h0503); ctrl_xfer(1, 3, 1, 16'd16); ctrl_xfer(1, 3, 2, 16'd8);
        ctrl_xfer(1, 3, 3, 16'd100);  ctrl_xfer(1, 3, 4, 16'd50);
        ctrl_xfer(1, 0, 0, 16'h0001); ctrl_xfer(1, 0, 1, 16'd8);  ctrl_xfer(1, 0, 2, 16'd12);
        ctrl_xfer(1, 0, 5, 16'h0021); ctrl_xfer(1, 0, 6, 16'd4);
        ctrl_xfer(1, 4, 0, 16'h0007); ctrl_xfer(1, 4, 1, 16'd4);  ctrl_xfer(1, 4, 2, 16'd4);
        ctrl_xfer(1, 5, 0, 16'h0001); ctrl_xfer(1, 5, 2, 16'd4);  ctrl_xfer(1, 5, 6, 16'd4);

        do_pix(3, 105, 52); do_pix(3, 116, 52); do_pix(3, 99, 52); do_pix(3, 105, 58);
        do_pix(3, 115, 57); do_pix(0, 25, 3);   do_pix(0, 32, 3);  do_pix(0, 31, 11);
        do_pix(0, 5, 12);   do_pix(9, 5, 5);    do_pix(4, 1, 1);   do_pix(5, 0, 0);
        step(3);
        for (int r = 0; r < 5; r++) ctrl_xfer(0, 3, r, 16'h0);

        // Sweep targets: animated sprite L7, non-animated sprite L8
        ctrl_xfer(1, 7, 0, 16'h000B); ctrl_xfer(1, 7, 1, 16'd4);  ctrl_xfer(1, 7, 2, 16'd4);
        ctrl_xfer(1, 7, 3, 16'd10);   ctrl_xfer(1, 7, 4, 16'd20);
        ctrl_xfer(1, 7, 5, 16'hFFFD); ctrl_xfer(1, 7, 6, 16'd1);  ctrl_xfer(1, 7, 7, 16'h0203);
        ctrl_xfer(1, 8, 0, 16'h0003); ctrl_xfer(1, 8, 3, 16'd5);
        ctrl_xfer(1, 8, 5, 16'd2);    ctrl_xfer(1, 8, 7, 16'h0105);
        step(2);

        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        s = cyc;
        chk("busy_after_start", update_busy, 1);
        chk("ready_low_busy", ctrl_ready, 0);
        step(9);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("overrun_pulse", update_overrun, 1);
        step();
        chk("overrun_clears", update_overrun, 0);
        model_sweep();
        chk("ready_low_midsweep", ctrl_ready, 0);
        ctrl_xfer(1, 7, 2, 16'd9);
        chk("done_before_write", done_cnt, 1);
        chk("sweep_length", done_cyc - s, 64);
        chk("busy_after_done", update_busy, 0);

        ctrl_xfer(0, 7, 2, 16'h0); ctrl_xfer(0, 7, 3, 16'h0); ctrl_xfer(0, 7, 4, 16'h0);
        ctrl_xfer(0, 7, 7, 16'h0); ctrl_xfer(0, 8, 3, 16'h0); ctrl_xfer(0, 8, 7, 16'h0);
        ctrl_xfer(0, 0, 5, 16'h0); ctrl_xfer(0, 0, 6, 16'h0); ctrl_xfer(0, 3, 3, 16'h0);
        ctrl_xfer(1, 7, 7, 16'h0105);
        ctrl_xfer(0, 7, 7, 16'h0);
        do_pix(7, 8, 22);
        do_pix(3, 105, 52);
        step(3);

        // Clear and write to the same layer on the same edge
        clear_valid = 1'b1; clear_layer = 5'd3;
        ctrl_valid = 1'b1; ctrl_write = 1'b1; ctrl_layer = 5'd3; ctrl_reg = 3'd0; ctrl_wdata = 16'hFFFF;
        step();
        clear_valid = 1'b0; ctrl_valid = 1'b0;
        for (int r = 0; r < 8; r++) mdl[3][r] = '0;
        for (int r = 0; r < 8; r++) ctrl_xfer(0, 3, r, 16'h0);
        step(4);
        chk("rdq_drained", rdq.size(), 0);
        chk("pixq_drained", pixq.size(), 0);
        chk("single_done", done_cnt, 1);

        // Reset in the middle of a sweep
        do_pix(7, 8, 22);
        step(3);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step(5);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", update_busy, 0);
        chk("rst_mid_ready", ctrl_ready, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_width", layer_width, 0);
        chk("rst_mid_layer_x", $unsigned(layer_x), 0);
        chk("rst_mid_done", update_done, 0);
        model_clear_all();
        step(2);
        reset = 1'b1;
        step(70);
        chk("no_done_after_abort", done_cnt, 1);
        chk("idle_after_abort", update_busy, 0);
        ctrl_xfer(0, 7, 0, 16'h0); ctrl_xfer(0, 7, 3, 16'h0); ctrl_xfer(0, 7, 7, 16'h0);
        do_pix(7, 8, 22);
        step(4);
        chk("rdq_empty_end", rdq.size(), 0);
        chk("pixq_empty_end", pixq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_header_engine.md
Name: layer_header_engine

Overview:
- Parametrised successor to the layer header store. Holds NUM_LAYERS headers of REGS×DATA_W bits in flops; controller reads and writes them through a ready/valid port.
- Serves the per-pixel render pipeline through a registered 2-stage lookup that produces bounds-checked memory enables and layer-relative coordinates.
- Adds a frame-start update sequencer: applies sprite velocity to position and advances animation frames, so the controller no longer has to write these back itself.

Parameters:
- NUM_LAYERS, 32, number of layer headers.
- LAYER_W, 5, layer index width (= clog2(NUM_LAYERS)).
- DATA_W, 16, width of one virtual register.
- COORD_W, 11, width of pixel X/Y inputs.

Ports:
- clk  in  1  GPU clock
- reset  in  1  asynchronous, active-low reset
- ctrl_valid  in  1  controller request valid
- ctrl_ready  out  1  engine can accept request
- ctrl_write  in  1  1=write, 0=read
- ctrl_layer  in  LAYER_W  target layer
- ctrl_reg  in  3  register index 0..7
- ctrl_wdata  in  DATA_W  write data
- ctrl_rdata  out  DATA_W  read data
- ctrl_rvalid  out  1  read data valid pulse
- clear_valid  in  1  zero one layer's header
- clear_layer  in  LAYER_W  layer to clear
- frame_start  in  1  start update sweep
- update_busy  out  1  sweep in progress
- update_done  out  1  one-cycle pulse at sweep end
- update_overrun  out  1  pulse when frame_start arrives while busy
- pix_valid  in  1  pixel lookup request
- pix_layer  in  LAYER_W  layer for this pixel
- pix_x, pix_y  in  COORD_W each  screen pixel
- out_valid  out  1  lookup result valid
- read_ram_en, read_flash_en  out  1 each  memory enables
- layer_id  out  8  header[15:8]
- layer_width, layer_height  out  DATA_W each  registers 1, 2
- layer_x, layer_y  out  DATA_W signed  pixel minus position
- sprite_frame  out  8  header[127:120]
- font_index  out  DATA_W  register 5
- char_index  out  DATA_W  character under pixel

Behaviour:
- Header layout:
  - Reg0 is flags: bit0 populated, bit1 sprite(1)/text(0), bit2 hidden, bit3 animated, [15:8] ID.
  - Sprite: reg3/4 X/Y position (signed), reg5/6 X/Y velocity in signed pixels/frame, reg7[7:0] frame count, reg7[15:8] current frame.
  - Text: reg5 font index, reg6 character count.
- Reset (reset=0, async): all headers 0, FSM IDLE, every output 0, ctrl_ready 0 during reset and 1 on the first cycle after release.
- Controller port:
  - A request is accepted when ctrl_valid && ctrl_ready. A write commits on that edge.
  - A read returns ctrl_rdata with ctrl_rvalid high exactly 1 cycle after acceptance. It returns the value as of before any same-edge write.
  - ctrl_ready=0 while update_busy.
- Clear:
  - clear_valid zeroes all 8 registers of clear_layer in 1 cycle.
  - It is ignored while update_busy.
  - If a controller write to the same layer is accepted on the same edge, the clear wins.
- Pixel path (latency 2; pix_valid pipelines to out_valid):
  - Stage 1 registers the header and computes layer_x=pix_x−posX and layer_y=pix_y−posY. Both are 16-bit signed, with pix zero-extended and wrapping.
  - Stage 2 registers the outputs.
  - in_y = 0 ≤ layer_y < height.
  - Sprite: read_ram_en = populated & !hidden & 0 ≤ layer_x < width & in_y. read_flash_en = 0.
  - Text: both enables = populated & !hidden & 0 ≤ layer_x < width×charcount & in_y. The product is 32 bits unsigned.
  - char_index = layer_x >> floor(log2(width)). Font widths are powers of two; width 0 gives char_index 0.
  - When not populated, both enables are 0. The data outputs are still driven.
- Update FSM: IDLE → RD → WR → (next layer RD | DONE) → IDLE.
  - A frame_start in IDLE starts the sweep at layer 0 and raises update_busy.
  - Each layer takes 2 cycles, so the sweep runs 2×NUM_LAYERS cycles; update_done then pulses 1 cycle.
  - WR applies only to layers that are populated and sprite:
    - posX += velX and posY += velY, 16-bit wrapping.
    - If animated: frame = (frame+1 ≥ count) ? 0 : frame+1. Count 0 or 1 keeps frame at 0.
  - Layers that are not populated or are text are left unchanged.
  - A frame_start while busy is ignored and pulses update_overrun.
  - Pixel lookups stay live during the sweep. They see a layer's pre- or post-update value depending on timing.
  - Reset mid-sweep aborts to IDLE with no done pulse.

Decomposition:
- Shared package layer_hdr_pkg holds:
  - register index constants (REG_FLAGS … REG_ANIM);
  - flag bit positions;
  - the FSM state enum;
  - a header struct with sprite/text views.
- Sub-module layer_pixel_lookup holds the 2-stage pixel path, including the bounds checks and the log2 shift.

Test Plan:
- Write sprite L3 (flags=0x0503, w=16, h=8, posX=100, posY=50), then pix (3,105,52) → 2 cycles later read_ram_en=1, layer_x=5, layer_y=2, layer_id=5. pix (3,116,52) → read_ram_en=0.
- Text L0 (flags=0x0001, w=8, h=12, charcount=4, pos 0,0), pix (0,25,3) → read_ram_en=read_flash_en=1, char_index=3. pix x=32 → both 0.
- Sprite posX=10, velX=−3, flags=0x000B, count=3, frame=2, frame_start → after 64 cycles update_done. posX=7, frame=0. Frame_start at cycle 10 of the sweep → update_overrun pulse.
- ctrl_valid write during sweep → ctrl_ready=0, write held until done. Read-after-write of reg7 returns the new value with rvalid 1 cycle later.
- clear_valid on L3 with a simultaneous ctrl write to L3 → all regs of L3 read back 0.
- Assert reset mid-sweep → outputs 0, headers 0, update_busy=0 immediately (async).
